instr_encoder: RTL and testbench

//   Inverse of the control unit's decode path. Accepts decoded RV32I fields (class, funct3, funct7_5, rd/rs1/rs2, imm)

---
 rtl/enc_pkg.sv | 36 +++
 rtl/instr_pack.sv | 53 +++++
 rtl/instr_encoder.sv | 109 ++++++++++
 tb/tb_instr_encoder.sv | 373 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/enc_pkg.sv
// Shared opcodes, field-bundle struct and FSM state type for the RV32I
// instruction encoder and its combinational packer.
package enc_pkg;

  localparam logic [6:0] OP_R = 7'b0110011;
  localparam logic [6:0] OP_I = 7'b0010011;
  localparam logic [6:0] OP_L = 7'b0000011;
  localparam logic [6:0] OP_S = 7'b0100011;
  localparam logic [6:0] OP_B = 7'b1100011;

  typedef enum logic [2:0] {
    CLS_R      = 3'd0,
    CLS_I_ALU  = 3'd1,
    CLS_LOAD   = 3'd2,
    CLS_STORE  = 3'd3,
    CLS_BRANCH = 3'd4
  } cls_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // cls kept as raw bits so reserved encodings 5-7 survive into the packer
  typedef struct packed {
    logic [2:0]  cls;
    logic [2:0]  f3;
    logic        f7_5;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [12:0] imm;
  } fields_t;

endpackage

// File: rtl/instr_pack.sv
// Combinational RV32I field packer: decoded fields -> 32-bit word + illegal flag.
// Defining ENC_CHECK_EN adds encoding legality checks on top of reserved-class detection.
module instr_pack
  import enc_pkg::*;
(
  input  fields_t     f,
  output logic [31:0] word,
  output logic        illegal
);

  always_comb begin
    word    = '0;
    illegal = 1'b0;
    case (f.cls)
      CLS_R: begin
        word = {1'b0, f.f7_5, 5'b0, f.rs2, f.rs1, f.f3, f.rd, OP_R};
`ifdef ENC_CHECK_EN
        if (f.f7_5 && f.f3 != 3'b000 && f.f3 != 3'b101) illegal = 1'b1;
`endif
      end
      CLS_I_ALU: begin
        // shifts carry shamt in imm[4:0] and the arith/logical select in bit 30
        if (f.f3 == 3'b001 || f.f3 == 3'b101)
          word = {1'b0, f.f7_5, 5'b0, f.imm[4:0], f.rs1, f.f3, f.rd, OP_I};
        else
          word = {f.imm[11:0], f.rs1, f.f3, f.rd, OP_I};
`ifdef ENC_CHECK_EN
        if (f.f7_5 && f.f3 != 3'b101) illegal = 1'b1;
`endif
      end
      CLS_LOAD: begin
        word = {f.imm[11:0], f.rs1, f.f3, f.rd, OP_L};
`ifdef ENC_CHECK_EN
        if (f.f3 != 3'b010) illegal = 1'b1;
`endif
      end
      CLS_STORE: begin
        word = {f.imm[11:5], f.rs2, f.rs1, f.f3, f.imm[4:0], OP_S};
`ifdef ENC_CHECK_EN
        if (f.f3 != 3'b010) illegal = 1'b1;
`endif
      end
      CLS_BRANCH: begin
        word = {f.imm[12], f.imm[10:5], f.rs2, f.rs1, f.f3, f.imm[4:1], f.imm[11], OP_B};
`ifdef ENC_CHECK_EN
        if (f.imm[0]) illegal = 1'b1;
`endif
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/instr_encoder.sv
// Streams decoded RV32I field bundles into sequential instruction-memory writes.
// Legality checking is enabled by defining ENC_CHECK_EN (implemented in instr_pack).
module instr_encoder
  import enc_pkg::*;
#(
  parameter int  DEPTH = 64,
  parameter int  BASE  = 0,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [2:0]    in_cls,
  input  logic [2:0]    in_funct3,
  input  logic          in_f7_5,
  input  logic [4:0]    in_rd,
  input  logic [4:0]    in_rs1,
  input  logic [4:0]    in_rs2,
  input  logic [12:0]   in_imm,
  input  logic          in_last,
  output logic          wr_en,
  input  logic          mem_ready,
  output logic [AW-1:0] wr_addr,
  output logic [31:0]   wr_data,
  output logic          done,
  output logic [AW:0]   count,
  output logic          err
);

  localparam logic [AW:0]   DEPTH_C   = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);
  localparam logic [AW-1:0] BASE_ADDR = AW'(BASE);

  state_e      state;
  logic        last_pend;
  fields_t     f;
  logic [31:0] pk_word;
  logic        pk_ill;
  logic        wr_fire, accept, full_hit, prog_end;
  logic [AW:0] occ;

  assign f = '{cls: in_cls, f3: in_funct3, f7_5: in_f7_5, rd: in_rd,
               rs1: in_rs1, rs2: in_rs2, imm: in_imm};

  instr_pack u_pack (.f(f), .word(pk_word), .illegal(pk_ill));

  assign wr_fire  = wr_en & mem_ready;
  assign occ      = count + {{AW{1'b0}}, wr_en};
  // once the last bundle is taken nothing more enters until the program closes
  assign in_ready = (state == RUN) & ~last_pend & (~wr_en | mem_ready) & (occ < DEPTH_C);
  assign accept   = in_valid & in_ready;
  assign full_hit = (state == RUN) & in_valid & (count == DEPTH_C);
  assign prog_end = (state == RUN) & last_pend & (~wr_en | mem_ready);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      last_pend <= 1'b0;
      wr_en     <= 1'b0;
      wr_addr   <= BASE_ADDR;
      wr_data   <= '0;
      count     <= '0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else if (start) begin
      state     <= RUN;
      last_pend <= 1'b0;
      wr_en     <= 1'b0;
      wr_addr   <= BASE_ADDR;
      count     <= '0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        RUN: begin
          if (wr_fire) begin
            count <= count + (AW+1)'(1);
            if (wr_addr != LAST_ADDR) wr_addr <= wr_addr + AW'(1);
          end
          if (accept) begin
            last_pend <= in_last;
            if (pk_ill) begin
              wr_en <= 1'b0;
              err   <= 1'b1;
            end else begin
              wr_en   <= 1'b1;
              wr_data <= pk_word;
            end
          end else if (wr_fire) begin
            wr_en <= 1'b0;
          end
          if (full_hit) err <= 1'b1;
          if (prog_end) begin
            state     <= DONE;
            done      <= 1'b1;
            wr_en     <= 1'b0;
            last_pend <= 1'b0;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Bench for instr_encoder (DEPTH=4): directed vector table, stall/full/restart
// sequences, and random programs checked against an arithmetic reference model.
module tb_instr_encoder;
  localparam int DEPTH = 4;
  localparam int BASE  = 0;
  localparam int AW    = $clog2(DEPTH);

  logic          clk = 1'b0;
  logic          rst_n, start, in_valid, in_f7_5, in_last, mem_ready;
  logic [2:0]    in_cls, in_funct3;
  logic [4:0]    in_rd, in_rs1, in_rs2;
  logic [12:0]   in_imm;
  logic          in_ready, wr_en, done, err;
  logic [AW-1:0] wr_addr;
  logic [31:0]   wr_data;
  logic [AW:0]   count;

  instr_encoder #(.DEPTH(DEPTH), .BASE(BASE)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .in_cls(in_cls), .in_funct3(in_funct3), .in_f7_5(in_f7_5), .in_rd(in_rd),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm), .in_last(in_last),
    .wr_en(wr_en), .mem_ready(mem_ready), .wr_addr(wr_addr), .wr_data(wr_data),
    .done(done), .count(count), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  cls;
    logic [2:0]  f3;
    logic        f7;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [12:0] imm;
  } bnd_t;

  typedef struct {
    bnd_t        b;
    logic        wr;
    logic [31:0] data;
  } vec_t;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  bit rand_mr = 0;

  // observed memory writes
  logic [AW-1:0] got_addr[$];
  logic [31:0]   got_data[$];
  int            got_cyc[$];
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk)
    if (rst_n && wr_en && mem_ready) begin
      got_addr.push_back(wr_addr);
      got_data.push_back(wr_data);
      got_cyc.push_back(cyc);
    end

  // reference model state
  logic [AW-1:0] exp_addr[$];
  logic [31:0]   exp_data[$];
  int            exp_n;
  bit            exp_err;
  int            rd_ptr;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  function automatic bit ref_legal(bnd_t b);
    if (b.cls > 3'd4) return 1'b0;
`ifdef ENC_CHECK_EN
    if (b.cls == 3'd4 && b.imm[0]) return 1'b0;
    if (b.cls == 3'd0 && b.f7 && !(b.f3 == 3'd0 || b.f3 == 3'd5)) return 1'b0;
    if (b.cls == 3'd1 && b.f7 && b.f3 != 3'd5) return 1'b0;
    if ((b.cls == 3'd2 || b.cls == 3'd3) && b.f3 != 3'd2) return 1'b0;
`endif
    return 1'b1;
  endfunction

  function automatic logic [31:0] ref_pack(bnd_t b);
    logic [31:0] imm, w, rd, f3, rs1, rs2;
    imm = 32'(b.imm);
    rd  = 32'(b.rd) << 7;
    f3  = 32'(b.f3) << 12;
    rs1 = 32'(b.rs1) << 15;
    rs2 = 32'(b.rs2) << 20;
    case (b.cls)
      3'd0: w = 32'h33 | rd | f3 | rs1 | rs2 | (32'(b.f7) << 30);
      3'd1, 3'd2: begin
        if (b.cls == 3'd1 && (b.f3 == 3'd1 || b.f3 == 3'd5))
          imm = (imm & 32'h1F) | (32'(b.f7) << 10);
        else
          imm = imm & 32'hFFF;
        w = ((b.cls == 3'd1) ? 32'h13 : 32'h03) | rd | f3 | rs1 | (imm << 20);
      end
      3'd3: w = 32'h23 | ((imm & 32'd31) << 7) | f3 | rs1 | rs2 | (((imm >> 5) & 32'd127) << 25);
      3'd4: w = 32'h63 | (((imm >> 11) & 32'd1) << 7) | (((imm >> 1) & 32'd15) << 8) | f3 | rs1
                | rs2 | (((imm >> 5) & 32'd63) << 25) | (((imm >> 12) & 32'd1) << 31);
      default: w = 32'h0;
    endcase
    return w;
  endfunction

  task automatic model_accept(input bnd_t b);
    int a;
    if (ref_legal(b)) begin
      a = BASE + exp_n;
      if (a > DEPTH - 1) a = DEPTH - 1;
      exp_addr.push_back(AW'(a));
      exp_data.push_back(ref_pack(b));
      exp_n++;
    end else begin
      exp_err = 1'b1;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_mr) mem_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic drive(input bnd_t b, input bit last);
    in_valid  = 1'b1;
    in_cls    = b.cls;
    in_funct3 = b.f3;
    in_f7_5   = b.f7;
    in_rd     = b.rd;
    in_rs1    = b.rs1;
    in_rs2    = b.rs2;
    in_imm    = b.imm;
    in_last   = last;
  endtask

  task automatic send(input bnd_t b, input bit last);
    bit ok;
    ok = 1'b0;
    drive(b, last);
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      if (in_ready) ok = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    chk("accept", 32'(ok), 32'd1);
    if (ok) model_accept(b);
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
    rd_ptr  = got_data.size();
    exp_n   = 0;
    exp_err = 1'b0;
    exp_addr.delete();
    exp_data.delete();
  endtask

  task automatic wait_done(input string nm);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (done) begin ok = 1'b1; break; end
      tick();
    end
    chk({nm, "_done_seen"}, 32'(ok), 32'd1);
    tick();
  endtask

  task automatic check_writes(input string nm);
    int n;
    n = got_data.size() - rd_ptr;
    chk({nm, "_nwrites"}, 32'(n), 32'(exp_data.size()));
    for (int i = 0; i < exp_data.size() && i < n; i++) begin
      chk($sformatf("%s_addr%0d", nm, i), 32'(got_addr[rd_ptr+i]), 32'(exp_addr[i]));
      chk($sformatf("%s_data%0d", nm, i), got_data[rd_ptr+i], exp_data[i]);
    end
  endtask

  function automatic bnd_t rnd_bundle();
    bnd_t b;
    int r;
    r = $urandom_range(0, 15);
    b.cls = (r < 14) ? 3'(r % 5) : ((r == 14) ? 3'd5 : 3'd7);
    b.f3  = 3'($urandom_range(0, 7));
    if ((b.cls == 3'd2 || b.cls == 3'd3) && $urandom_range(0, 3) != 0) b.f3 = 3'd2;
    b.f7  = 1'($urandom_range(0, 1));
    b.rd  = 5'($urandom);
    b.rs1 = 5'($urandom);
    b.rs2 = 5'($urandom);
    b.imm = 13'($urandom);
    if (b.cls == 3'd4 && $urandom_range(0, 3) != 0) b.imm[0] = 1'b0;
    return b;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t vt[9];
    bnd_t bx;
    int   plen;
    vt[0] = '{'{3'd0, 3'd0, 1'b0, 5'd3,  5'd1, 5'd2, 13'd0},      1'b1, 32'h002081B3};
    vt[1] = '{'{3'd0, 3'd0, 1'b1, 5'd3,  5'd1, 5'd2, 13'd0},      1'b1, 32'h402081B3};
    vt[2] = '{'{3'd3, 3'd2, 1'b0, 5'd9,  5'd2, 5'd5, 13'd12},     1'b1, 32'h00512623};
    vt[3] = '{'{3'd4, 3'd1, 1'b0, 5'd31, 5'd1, 5'd2, 13'h1FF8},   1'b1, 32'hFE209CE3};
    vt[4] = '{'{3'd1, 3'd0, 1'b0, 5'd5,  5'd6, 5'd7, 13'h1FFF},   1'b1, 32'hFFF30293};
    vt[5] = '{'{3'd1, 3'd5, 1'b1, 5'd1,  5'd1, 5'd0, 13'h0FE3},   1'b1, 32'h4030D093};
    vt[6] = '{'{3'd2, 3'd2, 1'b0, 5'd10, 5'd2, 5'd0, 13'd8},      1'b1, 32'h00812503};
    vt[7] = '{'{3'd5, 3'd0, 1'b0, 5'd1,  5'd1, 5'd1, 13'd0},      1'b0, 32'h0};
`ifdef ENC_CHECK_EN
    vt[8] = '{'{3'd4, 3'd0, 1'b0, 5'd0,  5'd0, 5'd0, 13'd3},      1'b0, 32'h0};
`else
    vt[8] = '{'{3'd4, 3'd0, 1'b0, 5'd0,  5'd0, 5'd0, 13'd3},      1'b1, 32'h00000163};
`endif

    rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; in_last = 1'b0; mem_ready = 1'b1;
    in_cls = '0; in_funct3 = '0; in_f7_5 = 1'b0; in_rd = '0; in_rs1 = '0; in_rs2 = '0; in_imm = '0;
    exp_n = 0; exp_err = 1'b0; rd_ptr = 0;

    repeat (2) @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_wr_en",    32'(wr_en),    32'd0);
    chk("rst_done",     32'(done),     32'd0);
    chk("rst_err",      32'(err),      32'd0);
    chk("rst_wr_addr",  32'(wr_addr),  32'(BASE));
    chk("rst_wr_data",  wr_data,       32'd0);
    chk("rst_count",    32'(count),    32'd0);
    rst_n = 1'b1;
    tick();

    // single-bundle programs from the vector table
    foreach (vt[i]) begin
      do_start();
      send(vt[i].b, 1'b1);
      exp_addr.delete(); exp_data.delete();
      if (vt[i].wr) begin
        exp_addr.push_back(AW'(BASE));
        exp_data.push_back(vt[i].data);
      end
      wait_done($sformatf("vec%0d", i));
      chk($sformatf("vec%0d_count", i), 32'(count), 32'(vt[i].wr));
      chk($sformatf("vec%0d_err", i),   32'(err),   32'(!vt[i].wr));
      check_writes($sformatf("vec%0d", i));
    end

    // backpressure: output register holds for 3 stalled cycles, then 1 write/cycle
    do_start();
    mem_ready = 1'b0;
    send(vt[0].b, 1'b0);
    drive(vt[1].b, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall_wr_en",    32'(wr_en),    32'd1);
      chk("stall_wr_addr",  32'(wr_addr),  32'(BASE));
      chk("stall_wr_data",  wr_data,       32'h002081B3);
      chk("stall_in_ready", 32'(in_ready), 32'd0);
      tick();
    end
    mem_ready = 1'b1;
    @(negedge clk);
    chk("resume_in_ready", 32'(in_ready), 32'd1);
    tick();
    model_accept(vt[1].b);
    in_valid = 1'b0;
    send(vt[2].b, 1'b0);
    send(vt[3].b, 1'b1);
    wait_done("stall");
    check_writes("stall");
    if (got_data.size() - rd_ptr == 4)
      chk("stall_throughput", 32'(got_cyc[rd_ptr+3] - got_cyc[rd_ptr]), 32'd3);
    else
      chk("stall_throughput_nwrites", 32'(got_data.size() - rd_ptr), 32'd4);

    // overfill: 5th bundle is refused and raises err
    do_start();
    for (int i = 0; i < 4; i++) send(vt[4+(i%3)].b, 1'b0);
    drive(vt[0].b, 1'b0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("full_in_ready", 32'(in_ready), 32'd0);
      tick();
    end
    in_valid = 1'b0;
    @(negedge clk);
    chk("full_err",     32'(err),     32'd1);
    chk("full_count",   32'(count),   32'(DEPTH));
    chk("full_wr_addr", 32'(wr_addr), 32'(DEPTH-1));
    chk("full_wr_en",   32'(wr_en),   32'd0);
    check_writes("full");
    tick();

    // restart after full: err/count/addr cleared, done one cycle after last write
    do_start();
    @(negedge clk);
    chk("restart_err",   32'(err),     32'd0);
    chk("restart_count", 32'(count),   32'd0);
    chk("restart_addr",  32'(wr_addr), 32'(BASE));
    tick();
    send(vt[1].b, 1'b0);
    send(vt[6].b, 1'b1);
    begin
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 10 && !seen; i++) begin
        @(negedge clk);
        if (wr_en && mem_ready && wr_addr == AW'(BASE+1)) seen = 1'b1;
        else chk("restart_no_early_done", 32'(done), 32'd0);
      end
      chk("restart_last_write_seen", 32'(seen), 32'd1);
    end
    @(negedge clk);
    chk("restart_done_pulse", 32'(done),  32'd1);
    chk("restart_count2",     32'(count), 32'd2);
    @(negedge clk);
    chk("restart_done_low",   32'(done),  32'd0);
    check_writes("restart");
    tick();

    // asynchronous reset mid-program drops the pending word at once
    do_start();
    mem_ready = 1'b0;
    send(vt[2].b, 1'b0);
    @(negedge clk);
    chk("midrst_pending", 32'(wr_en), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_wr_en",    32'(wr_en),    32'd0);
    chk("midrst_count",    32'(count),    32'd0);
    chk("midrst_in_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    mem_ready = 1'b1;
    tick();
    @(negedge clk);
    chk("midrst_idle_ready", 32'(in_ready), 32'd0);
    chk("midrst_idle_wr_en", 32'(wr_en),    32'd0);
    tick();

    // random programs with random backpressure against the reference model
    rand_mr = 1'b1;
    for (int p = 0; p < 40; p++) begin
      do_start();
      plen = $urandom_range(1, DEPTH);
      for (int k = 0; k < plen; k++) begin
        bx = rnd_bundle();
        send(bx, k == plen - 1);
      end
      wait_done($sformatf("rnd%0d", p));
      chk($sformatf("rnd%0d_count", p), 32'(count), 32'(exp_n));
      chk($sformatf("rnd%0d_err", p),   32'(err),   32'(exp_err));
      check_writes($sformatf("rnd%0d", p));
    end
    rand_mr = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
